// File: rtl/ysyx_22050019_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4 arbiter.
// Reads: round-robin, locked for a whole burst; writes: LSU pass-through.
module ysyx_22050019_axi_arbiter #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int LEN_W          = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  // IFU read master
  input  logic                        i_ifu_ar_valid,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_ifu_ar_addr,
  input  logic [LEN_W-1:0]            i_ifu_ar_len,
  input  logic [2:0]                  i_ifu_ar_size,
  output logic                        o_ifu_ar_ready,
  output logic                        o_ifu_r_valid,
  output logic [AXI_DATA_WIDTH-1:0]   o_ifu_r_data,
  output logic [1:0]                  o_ifu_r_resp,
  output logic                        o_ifu_r_last,
  input  logic                        i_ifu_r_ready,
  // LSU read/write master
  input  logic                        i_lsu_ar_valid,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_lsu_ar_addr,
  input  logic [LEN_W-1:0]            i_lsu_ar_len,
  input  logic [2:0]                  i_lsu_ar_size,
  output logic                        o_lsu_ar_ready,
  output logic                        o_lsu_r_valid,
  output logic [AXI_DATA_WIDTH-1:0]   o_lsu_r_data,
  output logic [1:0]                  o_lsu_r_resp,
  output logic                        o_lsu_r_last,
  input  logic                        i_lsu_r_ready,
  input  logic                        i_lsu_aw_valid,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_lsu_aw_addr,
  input  logic [LEN_W-1:0]            i_lsu_aw_len,
  input  logic [2:0]                  i_lsu_aw_size,
  output logic                        o_lsu_aw_ready,
  input  logic                        i_lsu_w_valid,
  input  logic [AXI_DATA_WIDTH-1:0]   i_lsu_w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] i_lsu_w_strb,
  input  logic                        i_lsu_w_last,
  output logic                        o_lsu_w_ready,
  output logic                        o_lsu_b_valid,
  output logic [1:0]                  o_lsu_b_resp,
  input  logic                        i_lsu_b_ready,
  // shared slave
  output logic                        o_s_ar_valid,
  output logic [AXI_ADDR_WIDTH-1:0]   o_s_ar_addr,
  output logic [LEN_W-1:0]            o_s_ar_len,
  output logic [2:0]                  o_s_ar_size,
  output logic [2:0]                  o_s_ar_prot,
  output logic [1:0]                  o_s_ar_burst,
  input  logic                        i_s_ar_ready,
  input  logic                        i_s_r_valid,
  input  logic [AXI_DATA_WIDTH-1:0]   i_s_r_data,
  input  logic [1:0]                  i_s_r_resp,
  input  logic                        i_s_r_last,
  output logic                        o_s_r_ready,
  output logic                        o_s_aw_valid,
  output logic [AXI_ADDR_WIDTH-1:0]   o_s_aw_addr,
  output logic [LEN_W-1:0]            o_s_aw_len,
  output logic [2:0]                  o_s_aw_size,
  output logic [2:0]                  o_s_aw_prot,
  output logic [1:0]                  o_s_aw_burst,
  input  logic                        i_s_aw_ready,
  output logic                        o_s_w_valid,
  output logic [AXI_DATA_WIDTH-1:0]   o_s_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] o_s_w_strb,
  output logic                        o_s_w_last,
  input  logic                        i_s_w_ready,
  input  logic                        i_s_b_valid,
  input  logic [1:0]                  i_s_b_resp,
  output logic                        o_s_b_ready
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_IFU  = 2'd1;
  localparam logic [1:0] R_LSU  = 2'd2;
  localparam logic GRANT_IFU = 1'b0;
  localparam logic GRANT_LSU = 1'b1;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_last_grant;
  logic       w_grant_nxt;
  logic       r_ar_done;

  logic w_on, w_ifu_sel, w_lsu_sel, w_addr_ph, w_pick_lsu;
  logic w_ar_hs, w_r_end;

  assign w_on      = !rst;
  assign w_ifu_sel = w_on && (r_state == R_IFU);
  assign w_lsu_sel = w_on && (r_state == R_LSU);
  assign w_addr_ph = (w_ifu_sel || w_lsu_sel) && !r_ar_done;

  // read address: granted master's request, only until the slave accepts it
  assign o_s_ar_valid = w_addr_ph && (w_ifu_sel ? i_ifu_ar_valid : i_lsu_ar_valid);
  assign o_s_ar_addr  = !w_addr_ph ? '0 : (w_ifu_sel ? i_ifu_ar_addr : i_lsu_ar_addr);
  assign o_s_ar_len   = !w_addr_ph ? '0 : (w_ifu_sel ? i_ifu_ar_len  : i_lsu_ar_len);
  assign o_s_ar_size  = !w_addr_ph ? '0 : (w_ifu_sel ? i_ifu_ar_size : i_lsu_ar_size);
  assign o_s_ar_prot  = 3'b000;
  assign o_s_ar_burst = w_on ? 2'b01 : 2'b00;
  assign o_ifu_ar_ready = w_addr_ph && w_ifu_sel && i_s_ar_ready;
  assign o_lsu_ar_ready = w_addr_ph && w_lsu_sel && i_s_ar_ready;

  assign o_s_r_ready  = (w_ifu_sel && i_ifu_r_ready) || (w_lsu_sel && i_lsu_r_ready);
  assign o_ifu_r_valid = w_ifu_sel && i_s_r_valid;
  assign o_ifu_r_data  = w_ifu_sel ? i_s_r_data : '0;
  assign o_ifu_r_resp  = w_ifu_sel ? i_s_r_resp : 2'b00;
  assign o_ifu_r_last  = w_ifu_sel && i_s_r_last;
  assign o_lsu_r_valid = w_lsu_sel && i_s_r_valid;
  assign o_lsu_r_data  = w_lsu_sel ? i_s_r_data : '0;
  assign o_lsu_r_resp  = w_lsu_sel ? i_s_r_resp : 2'b00;
  assign o_lsu_r_last  = w_lsu_sel && i_s_r_last;

  assign w_ar_hs = o_s_ar_valid && i_s_ar_ready;
  assign w_r_end = i_s_r_valid && o_s_r_ready && i_s_r_last;

  // on a tie the master that did not win last time gets the bus
  assign w_pick_lsu = i_lsu_ar_valid && (!i_ifu_ar_valid || (r_last_grant == GRANT_IFU));

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_last_grant;
    case (r_state)
      R_IDLE: begin
        if (i_ifu_ar_valid || i_lsu_ar_valid) begin
          w_state_nxt = w_pick_lsu ? R_LSU : R_IFU;
          w_grant_nxt = w_pick_lsu ? GRANT_LSU : GRANT_IFU;
        end
      end
      R_IFU, R_LSU: begin
        if (w_r_end) w_state_nxt = R_IDLE;
      end
      default: w_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= R_IDLE;
      r_last_grant <= GRANT_LSU;
      r_ar_done    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_grant_nxt;
      if (w_r_end)      r_ar_done <= 1'b0;
      else if (w_ar_hs) r_ar_done <= 1'b1;
    end
  end

  // write channels belong to the LSU alone
  assign o_s_aw_valid   = w_on && i_lsu_aw_valid;
  assign o_s_aw_addr    = w_on ? i_lsu_aw_addr : '0;
  assign o_s_aw_len     = w_on ? i_lsu_aw_len  : '0;
  assign o_s_aw_size    = w_on ? i_lsu_aw_size : '0;
  assign o_s_aw_prot    = 3'b000;
  assign o_s_aw_burst   = w_on ? 2'b01 : 2'b00;
  assign o_lsu_aw_ready = w_on && i_s_aw_ready;
  assign o_s_w_valid    = w_on && i_lsu_w_valid;
  assign o_s_w_data     = w_on ? i_lsu_w_data : '0;
  assign o_s_w_strb     = w_on ? i_lsu_w_strb : '0;
  assign o_s_w_last     = w_on && i_lsu_w_last;
  assign o_lsu_w_ready  = w_on && i_s_w_ready;
  assign o_lsu_b_valid  = w_on && i_s_b_valid;
  assign o_lsu_b_resp   = w_on ? i_s_b_resp : 2'b00;
  assign o_s_b_ready    = w_on && i_lsu_b_ready;

endmodule

// File: tb/tb_ysyx_22050019_axi_arbiter.sv
// Bench for the AXI read arbiter: slave model, per-master read-beat scoreboards,
// and scenario tasks for arbitration order, burst lock, write pass-through and reset.
module tb_ysyx_22050019_axi_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        i_ifu_ar_valid = 0, i_ifu_r_ready = 1;
  logic [31:0] i_ifu_ar_addr = 0;
  logic [7:0]  i_ifu_ar_len = 0;
  logic [2:0]  i_ifu_ar_size = 3;
  logic        o_ifu_ar_ready, o_ifu_r_valid, o_ifu_r_last;
  logic [63:0] o_ifu_r_data;
  logic [1:0]  o_ifu_r_resp;
  logic        i_lsu_ar_valid = 0, i_lsu_r_ready = 1;
  logic [31:0] i_lsu_ar_addr = 0;
  logic [7:0]  i_lsu_ar_len = 0;
  logic [2:0]  i_lsu_ar_size = 3;
  logic        o_lsu_ar_ready, o_lsu_r_valid, o_lsu_r_last;
  logic [63:0] o_lsu_r_data;
  logic [1:0]  o_lsu_r_resp;
  logic        i_lsu_aw_valid = 0, i_lsu_w_valid = 0, i_lsu_w_last = 0, i_lsu_b_ready = 0;
  logic [31:0] i_lsu_aw_addr = 0;
  logic [7:0]  i_lsu_aw_len = 0;
  logic [2:0]  i_lsu_aw_size = 0;
  logic [63:0] i_lsu_w_data = 0;
  logic [7:0]  i_lsu_w_strb = 0;
  logic        o_lsu_aw_ready, o_lsu_w_ready, o_lsu_b_valid;
  logic [1:0]  o_lsu_b_resp;
  logic        o_s_ar_valid, o_s_r_ready, o_s_aw_valid, o_s_w_valid, o_s_w_last, o_s_b_ready;
  logic [31:0] o_s_ar_addr, o_s_aw_addr;
  logic [7:0]  o_s_ar_len, o_s_aw_len, o_s_w_strb;
  logic [2:0]  o_s_ar_size, o_s_ar_prot, o_s_aw_size, o_s_aw_prot;
  logic [1:0]  o_s_ar_burst, o_s_aw_burst;
  logic [63:0] o_s_w_data;
  logic        i_s_ar_ready = 0, i_s_r_valid = 0, i_s_r_last = 0;
  logic [63:0] i_s_r_data = 0;
  logic [1:0]  i_s_r_resp = 0;
  logic        i_s_aw_ready = 0, i_s_w_ready = 0, i_s_b_valid = 0;
  logic [1:0]  i_s_b_resp = 0;

  ysyx_22050019_axi_arbiter #(.AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(32), .LEN_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .i_ifu_ar_valid(i_ifu_ar_valid), .i_ifu_ar_addr(i_ifu_ar_addr), .i_ifu_ar_len(i_ifu_ar_len),
    .i_ifu_ar_size(i_ifu_ar_size), .o_ifu_ar_ready(o_ifu_ar_ready), .o_ifu_r_valid(o_ifu_r_valid),
    .o_ifu_r_data(o_ifu_r_data), .o_ifu_r_resp(o_ifu_r_resp), .o_ifu_r_last(o_ifu_r_last),
    .i_ifu_r_ready(i_ifu_r_ready),
    .i_lsu_ar_valid(i_lsu_ar_valid), .i_lsu_ar_addr(i_lsu_ar_addr), .i_lsu_ar_len(i_lsu_ar_len),
    .i_lsu_ar_size(i_lsu_ar_size), .o_lsu_ar_ready(o_lsu_ar_ready), .o_lsu_r_valid(o_lsu_r_valid),
    .o_lsu_r_data(o_lsu_r_data), .o_lsu_r_resp(o_lsu_r_resp), .o_lsu_r_last(o_lsu_r_last),
    .i_lsu_r_ready(i_lsu_r_ready),
    .i_lsu_aw_valid(i_lsu_aw_valid), .i_lsu_aw_addr(i_lsu_aw_addr), .i_lsu_aw_len(i_lsu_aw_len),
    .i_lsu_aw_size(i_lsu_aw_size), .o_lsu_aw_ready(o_lsu_aw_ready),
    .i_lsu_w_valid(i_lsu_w_valid), .i_lsu_w_data(i_lsu_w_data), .i_lsu_w_strb(i_lsu_w_strb),
    .i_lsu_w_last(i_lsu_w_last), .o_lsu_w_ready(o_lsu_w_ready),
    .o_lsu_b_valid(o_lsu_b_valid), .o_lsu_b_resp(o_lsu_b_resp), .i_lsu_b_ready(i_lsu_b_ready),
    .o_s_ar_valid(o_s_ar_valid), .o_s_ar_addr(o_s_ar_addr), .o_s_ar_len(o_s_ar_len),
    .o_s_ar_size(o_s_ar_size), .o_s_ar_prot(o_s_ar_prot), .o_s_ar_burst(o_s_ar_burst),
    .i_s_ar_ready(i_s_ar_ready),
    .i_s_r_valid(i_s_r_valid), .i_s_r_data(i_s_r_data), .i_s_r_resp(i_s_r_resp),
    .i_s_r_last(i_s_r_last), .o_s_r_ready(o_s_r_ready),
    .o_s_aw_valid(o_s_aw_valid), .o_s_aw_addr(o_s_aw_addr), .o_s_aw_len(o_s_aw_len),
    .o_s_aw_size(o_s_aw_size), .o_s_aw_prot(o_s_aw_prot), .o_s_aw_burst(o_s_aw_burst),
    .i_s_aw_ready(i_s_aw_ready),
    .o_s_w_valid(o_s_w_valid), .o_s_w_data(o_s_w_data), .o_s_w_strb(o_s_w_strb),
    .o_s_w_last(o_s_w_last), .i_s_w_ready(i_s_w_ready),
    .i_s_b_valid(i_s_b_valid), .i_s_b_resp(i_s_b_resp), .o_s_b_ready(o_s_b_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int ifu_ar_cyc = -1, lsu_last_cyc = -1;
  logic [64:0] q_ifu[$];
  logic [64:0] q_lsu[$];
  bit grant_log[$];
  logic ar_rdy_en = 1'b1;
  logic inj_r = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] slv_data(input logic [31:0] a, input logic [7:0] b);
    return {a ^ 32'hA5A5_5A5A, 24'h0, b};
  endfunction

  // slave: single outstanding burst, one beat per cycle starting the cycle after AR
  initial begin
    logic busy, ar_hs, r_hs, rst_s;
    logic [31:0] sl_addr, cap_addr;
    logic [7:0]  sl_len, sl_beat, cap_len;
    busy = 0; sl_addr = 0; sl_len = 0; sl_beat = 0;
    forever begin
      @(negedge clk);
      ar_hs = o_s_ar_valid && i_s_ar_ready;
      r_hs  = i_s_r_valid && o_s_r_ready;
      rst_s = rst;
      cap_addr = o_s_ar_addr;
      cap_len  = o_s_ar_len;
      @(posedge clk); #1;
      if (rst_s) busy = 0;
      else begin
        if (r_hs && busy) begin
          if (sl_beat == sl_len) busy = 0;
          else sl_beat = sl_beat + 8'd1;
        end
        if (ar_hs) begin busy = 1; sl_addr = cap_addr; sl_len = cap_len; sl_beat = 0; end
      end
      i_s_r_valid  = busy | inj_r;
      i_s_r_data   = busy ? slv_data(sl_addr, sl_beat) : 64'hDEAD_BEEF_DEAD_BEEF;
      i_s_r_last   = busy && (sl_beat == sl_len);
      i_s_ar_ready = ar_rdy_en && !busy && !rst_s;
    end
  end

  // monitor: grant order and R-beat scoreboards
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (i_ifu_ar_valid && o_ifu_ar_ready) begin grant_log.push_back(1'b0); ifu_ar_cyc = cyc; end
      if (i_lsu_ar_valid && o_lsu_ar_ready) grant_log.push_back(1'b1);
      if (o_ifu_r_valid && i_ifu_r_ready) begin
        n_tests++;
        if (q_ifu.size() == 0) begin
          n_fail++; $display("FAIL ifu_r_unexpected got=%h expected none", o_ifu_r_data);
        end else begin
          e = q_ifu.pop_front();
          if ({o_ifu_r_last, o_ifu_r_data} !== e) begin
            n_fail++; $display("FAIL ifu_r_beat got=%h expected=%h", {o_ifu_r_last, o_ifu_r_data}, e);
          end
        end
      end
      if (o_lsu_r_valid && i_lsu_r_ready) begin
        n_tests++;
        if (o_lsu_r_last) lsu_last_cyc = cyc;
        if (q_lsu.size() == 0) begin
          n_fail++; $display("FAIL lsu_r_unexpected got=%h expected none", o_lsu_r_data);
        end else begin
          e = q_lsu.pop_front();
          if ({o_lsu_r_last, o_lsu_r_data} !== e) begin
            n_fail++; $display("FAIL lsu_r_beat got=%h expected=%h", {o_lsu_r_last, o_lsu_r_data}, e);
          end
        end
      end
      if (o_ifu_r_valid && o_lsu_r_valid) begin
        n_fail++; $display("FAIL r_valid_both got=1 expected=0");
      end
    end
  end

  task automatic do_req(input bit who, input logic [31:0] a, input logic [7:0] l);
    bit done = 0;
    for (int b = 0; b <= int'(l); b++) begin
      if (who) q_lsu.push_back({b == int'(l), slv_data(a, 8'(b))});
      else     q_ifu.push_back({b == int'(l), slv_data(a, 8'(b))});
    end
    if (who) begin i_lsu_ar_valid = 1; i_lsu_ar_addr = a; i_lsu_ar_len = l; end
    else     begin i_ifu_ar_valid = 1; i_ifu_ar_addr = a; i_ifu_ar_len = l; end
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = who ? o_lsu_ar_ready : o_ifu_ar_ready;
    end
    @(posedge clk); #1;
    if (who) i_lsu_ar_valid = 0; else i_ifu_ar_valid = 0;
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL ar_handshake_timeout master=%0d got=0 expected=1", who); end
  endtask

  task automatic drain();
    int t = 0;
    while ((q_ifu.size() != 0 || q_lsu.size() != 0) && t < 200) begin @(negedge clk); t++; end
    n_tests++;
    if (q_ifu.size() != 0 || q_lsu.size() != 0) begin
      n_fail++; $display("FAIL drain_timeout got=%0d/%0d beats left expected=0", q_ifu.size(), q_lsu.size());
    end
    q_ifu.delete(); q_lsu.delete();
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1;
    repeat (2) @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    i_ifu_ar_valid = 1; i_lsu_ar_valid = 1; i_lsu_aw_valid = 1; i_lsu_aw_addr = 32'h1234_5678;
    i_lsu_w_valid = 1; i_lsu_w_data = 64'hFFFF_0000_FFFF_0000; i_lsu_b_ready = 1;
    i_s_aw_ready = 1; i_s_w_ready = 1; i_s_b_valid = 1; i_s_b_resp = 2'b10; inj_r = 1;
    repeat (3) @(negedge clk);
    n_tests += 8;
    if ({o_ifu_ar_ready, o_lsu_ar_ready, o_ifu_r_valid, o_lsu_r_valid} !== 4'b0) begin
      n_fail++; $display("FAIL rst_master_read got=%b expected=0000", {o_ifu_ar_ready, o_lsu_ar_ready, o_ifu_r_valid, o_lsu_r_valid}); end
    if ({o_lsu_aw_ready, o_lsu_w_ready, o_lsu_b_valid} !== 3'b0) begin
      n_fail++; $display("FAIL rst_master_write got=%b expected=000", {o_lsu_aw_ready, o_lsu_w_ready, o_lsu_b_valid}); end
    if ({o_s_ar_valid, o_s_r_ready, o_s_aw_valid, o_s_w_valid, o_s_b_ready} !== 5'b0) begin
      n_fail++; $display("FAIL rst_slave_side got=%b expected=00000", {o_s_ar_valid, o_s_r_ready, o_s_aw_valid, o_s_w_valid, o_s_b_ready}); end
    if (o_s_aw_addr !== 32'h0) begin n_fail++; $display("FAIL rst_aw_addr got=%h expected=0", o_s_aw_addr); end
    if (o_s_w_data !== 64'h0) begin n_fail++; $display("FAIL rst_w_data got=%h expected=0", o_s_w_data); end
    if (o_ifu_r_data !== 64'h0) begin n_fail++; $display("FAIL rst_ifu_r_data got=%h expected=0", o_ifu_r_data); end
    if (o_lsu_b_resp !== 2'b0) begin n_fail++; $display("FAIL rst_b_resp got=%b expected=0", o_lsu_b_resp); end
    if (u_dut.r_state !== 2'd0) begin n_fail++; $display("FAIL rst_state got=%0d expected=0", u_dut.r_state); end
    @(posedge clk); #1;
    i_ifu_ar_valid = 0; i_lsu_ar_valid = 0; i_lsu_aw_valid = 0; i_lsu_aw_addr = 0;
    i_lsu_w_valid = 0; i_lsu_w_data = 0; i_lsu_b_ready = 0;
    i_s_aw_ready = 0; i_s_w_ready = 0; i_s_b_valid = 0; i_s_b_resp = 0; inj_r = 0;
    rst = 0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_ifu_alone();
    q_ifu.push_back({1'b1, slv_data(32'h8000_0000, 8'd0)});
    i_ifu_ar_valid = 1; i_ifu_ar_addr = 32'h8000_0000; i_ifu_ar_len = 0;
    @(negedge clk);
    n_tests++;
    if (o_s_ar_valid !== 1'b0) begin n_fail++; $display("FAIL arb_cycle_ar_valid got=%b expected=0", o_s_ar_valid); end
    @(negedge clk);
    n_tests += 4;
    if (o_s_ar_valid !== 1'b1) begin n_fail++; $display("FAIL ifu_s_ar_valid got=%b expected=1", o_s_ar_valid); end
    if (o_s_ar_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL ifu_s_ar_addr got=%h expected=80000000", o_s_ar_addr); end
    if (o_s_ar_burst !== 2'b01 || o_s_ar_prot !== 3'b000) begin
      n_fail++; $display("FAIL ar_const got=%b/%b expected=01/000", o_s_ar_burst, o_s_ar_prot); end
    if (o_ifu_ar_ready !== 1'b1) begin n_fail++; $display("FAIL ifu_ar_ready got=%b expected=1", o_ifu_ar_ready); end
    @(posedge clk); #1; i_ifu_ar_valid = 0;
    @(negedge clk);
    n_tests++;
    if (o_lsu_r_valid !== 1'b0 || o_ifu_r_valid !== 1'b1) begin
      n_fail++; $display("FAIL ifu_beat_route got=ifu%b/lsu%b expected=ifu1/lsu0", o_ifu_r_valid, o_lsu_r_valid); end
    @(negedge clk);
    n_tests++;
    if (u_dut.r_state !== 2'd0) begin n_fail++; $display("FAIL idle_after_last got=%0d expected=0", u_dut.r_state); end
    drain();
  endtask

  task automatic test_round_robin();
    do_reset();
    grant_log.delete();
    fork
      do_req(1'b0, 32'h8000_0100, 8'd0);
      do_req(1'b1, 32'h8000_0200, 8'd0);
    join
    drain();
    n_tests++;
    if (grant_log.size() != 2 || grant_log[0] != 1'b0 || grant_log[1] != 1'b1) begin
      n_fail++; $display("FAIL rr_first_pair got=%0d entries first=%0d expected=IFU(0) then LSU(1)", grant_log.size(), grant_log[0]); end
    do_req(1'b0, 32'h8000_0300, 8'd0);
    drain();
    grant_log.delete();
    fork
      do_req(1'b0, 32'h8000_0400, 8'd1);
      do_req(1'b1, 32'h8000_0500, 8'd1);
    join
    drain();
    n_tests++;
    if (grant_log.size() != 2 || grant_log[0] != 1'b1 || grant_log[1] != 1'b0) begin
      n_fail++; $display("FAIL rr_second_pair got=%0d entries first=%0d expected=LSU(1) then IFU(0)", grant_log.size(), grant_log[0]); end
  endtask

  task automatic test_burst_lock();
    ifu_ar_cyc = -1; lsu_last_cyc = -1;
    fork
      do_req(1'b1, 32'h8000_1000, 8'd1);
      begin repeat (2) @(posedge clk); #1; do_req(1'b0, 32'h8000_2000, 8'd0); end
    join
    drain();
    n_tests++;
    if (ifu_ar_cyc != lsu_last_cyc + 2) begin
      n_fail++; $display("FAIL lock_ifu_grant_cycle got=%0d expected=%0d", ifu_ar_cyc, lsu_last_cyc + 2); end
  endtask

  task automatic test_write_overlap();
    fork
      do_req(1'b0, 32'h8000_3000, 8'd1);
      begin
        i_lsu_aw_valid = 1; i_lsu_aw_addr = 32'h8000_0010; i_lsu_aw_len = 0; i_lsu_aw_size = 3;
        i_lsu_w_valid = 1; i_lsu_w_data = 64'h1122_3344_5566_7788; i_lsu_w_strb = 8'hFF; i_lsu_w_last = 1;
        i_s_aw_ready = 1; i_s_w_ready = 1;
        @(negedge clk);
        n_tests += 4;
        if (o_s_aw_valid !== 1'b1 || o_s_aw_addr !== 32'h8000_0010 || o_s_aw_len !== 8'd0 || o_s_aw_size !== 3'd3) begin
          n_fail++; $display("FAIL aw_pass got=%b/%h/%0d/%0d expected=1/80000010/0/3", o_s_aw_valid, o_s_aw_addr, o_s_aw_len, o_s_aw_size); end
        if (o_s_aw_burst !== 2'b01 || o_s_aw_prot !== 3'b000) begin
          n_fail++; $display("FAIL aw_const got=%b/%b expected=01/000", o_s_aw_burst, o_s_aw_prot); end
        if (o_s_w_valid !== 1'b1 || o_s_w_data !== 64'h1122_3344_5566_7788 || o_s_w_strb !== 8'hFF || o_s_w_last !== 1'b1) begin
          n_fail++; $display("FAIL w_pass got=%b/%h/%h/%b expected=1/1122334455667788/ff/1", o_s_w_valid, o_s_w_data, o_s_w_strb, o_s_w_last); end
        if (o_lsu_aw_ready !== 1'b1 || o_lsu_w_ready !== 1'b1) begin
          n_fail++; $display("FAIL aw_w_ready got=%b/%b expected=1/1", o_lsu_aw_ready, o_lsu_w_ready); end
        @(posedge clk); #1;
        i_lsu_aw_valid = 0; i_lsu_w_valid = 0; i_lsu_w_last = 0; i_s_aw_ready = 0; i_s_w_ready = 0;
        i_s_b_valid = 1; i_s_b_resp = 2'b00; i_lsu_b_ready = 1;
        @(negedge clk);
        n_tests += 2;
        if (o_lsu_b_valid !== 1'b1 || o_lsu_b_resp !== 2'b00) begin
          n_fail++; $display("FAIL b_pass got=%b/%b expected=1/00", o_lsu_b_valid, o_lsu_b_resp); end
        if (o_s_b_ready !== 1'b1 || o_s_aw_valid !== 1'b0) begin
          n_fail++; $display("FAIL b_ready got=%b aw_valid=%b expected=1/0", o_s_b_ready, o_s_aw_valid); end
        @(posedge clk); #1; i_s_b_valid = 0; i_lsu_b_ready = 0;
      end
    join
    drain();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    do_req(1'b1, 32'h8000_4000, 8'd3);
    rst = 1;
    @(negedge clk);
    n_tests++;
    if ({o_lsu_r_valid, o_lsu_ar_ready, o_ifu_ar_ready, o_s_ar_valid, o_s_r_ready} !== 5'b0) begin
      n_fail++; $display("FAIL mid_rst_outputs got=%b expected=00000", {o_lsu_r_valid, o_lsu_ar_ready, o_ifu_ar_ready, o_s_ar_valid, o_s_r_ready}); end
    @(negedge clk);
    n_tests++;
    if (u_dut.r_state !== 2'd0 || u_dut.r_ar_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_state got=%0d/%b expected=0/0", u_dut.r_state, u_dut.r_ar_done); end
    @(posedge clk); #1; rst = 0;
    q_lsu.delete();
    grant_log.delete();
    fork
      do_req(1'b0, 32'h8000_5000, 8'd0);
      do_req(1'b1, 32'h8000_6000, 8'd0);
    join
    drain();
    n_tests++;
    if (grant_log.size() != 2 || grant_log[0] != 1'b0) begin
      n_fail++; $display("FAIL post_rst_grant got=%0d entries first=%0d expected=IFU(0)", grant_log.size(), grant_log[0]); end
  endtask

  task automatic test_ar_stall();
    ar_rdy_en = 0;
    @(posedge clk); #1;
    fork
      do_req(1'b0, 32'h8000_7000, 8'd0);
      begin
        int t = 0;
        do begin @(negedge clk); t++; end while (!o_s_ar_valid && t < 10);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          n_tests++;
          if (o_s_ar_addr !== 32'h8000_7000 || o_ifu_ar_ready !== 1'b0 || u_dut.r_ar_done !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold got=%h/%b/%b expected=80007000/0/0", o_s_ar_addr, o_ifu_ar_ready, u_dut.r_ar_done); end
        end
        ar_rdy_en = 1;
        @(negedge clk);
        n_tests++;
        if (o_ifu_ar_ready !== 1'b1 || u_dut.r_ar_done !== 1'b0) begin
          n_fail++; $display("FAIL stall_release got=%b/%b expected=1/0", o_ifu_ar_ready, u_dut.r_ar_done); end
        @(negedge clk);
        n_tests++;
        if (u_dut.r_ar_done !== 1'b1 || o_s_ar_valid !== 1'b0) begin
          n_fail++; $display("FAIL ar_done_set got=%b/%b expected=1/0", u_dut.r_ar_done, o_s_ar_valid); end
      end
    join
    drain();
  endtask

  task automatic test_stray_r();
    inj_r = 1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({o_s_r_ready, o_ifu_r_valid, o_lsu_r_valid} !== 3'b0) begin
      n_fail++; $display("FAIL stray_r got=%b expected=000", {o_s_r_ready, o_ifu_r_valid, o_lsu_r_valid}); end
    inj_r = 0;
    repeat (2) @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_ifu_alone();
    test_round_robin();
    test_burst_lock();
    test_write_overlap();
    test_reset_mid_burst();
    test_ar_stall();
    test_stray_r();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ysyx_22050019_axi_arbiter.md
Name: ysyx_22050019_axi_arbiter

Overview:
- Two-master, one-slave AXI4 arbiter in front of the shared AXI SRAM slave.
- The IFU is a read-only master. The LSU is a read/write master.
- Read channels (AR/R) are arbitrated with round-robin and a burst-level lock.
- Write channels (AW/W/B) belong only to the LSU and pass straight through, gated only by reset.

Parameters:
AXI_DATA_WIDTH, 64, data bus width
AXI_ADDR_WIDTH, 32, address width
LEN_W, 8, burst length field width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ifu_ar_valid/ifu_ar_addr/ifu_ar_len/ifu_ar_size  in  1/ADDR/LEN_W/3  IFU read address
ifu_ar_ready  out  1  IFU read address accepted
ifu_r_valid/ifu_r_data/ifu_r_resp/ifu_r_last  out  1/DATA/2/1  IFU read data
ifu_r_ready  in  1  IFU read data accept
lsu_ar_valid/lsu_ar_addr/lsu_ar_len/lsu_ar_size  in  1/ADDR/LEN_W/3  LSU read address
lsu_ar_ready  out  1
lsu_r_valid/lsu_r_data/lsu_r_resp/lsu_r_last  out  1/DATA/2/1
lsu_r_ready  in  1
lsu_aw_valid/lsu_aw_addr/lsu_aw_len/lsu_aw_size  in  1/ADDR/LEN_W/3;  lsu_aw_ready  out  1
lsu_w_valid/lsu_w_data/lsu_w_strb/lsu_w_last  in  1/DATA/DATA/8/1;  lsu_w_ready  out  1
lsu_b_valid/lsu_b_resp  out  1/2;  lsu_b_ready  in  1
s_ar_valid/s_ar_addr/s_ar_len/s_ar_size/s_ar_prot/s_ar_burst  out  1/ADDR/LEN_W/3/3/2;  s_ar_ready  in  1
s_r_valid/s_r_data/s_r_resp/s_r_last  in  1/DATA/2/1;  s_r_ready  out  1
s_aw_valid/s_aw_addr/s_aw_len/s_aw_size/s_aw_prot/s_aw_burst  out  1/ADDR/LEN_W/3/3/2;  s_aw_ready  in  1
s_w_valid/s_w_data/s_w_strb/s_w_last  out  1/DATA/DATA/8/1;  s_w_ready  in  1
s_b_valid/s_b_resp  in  1/2;  s_b_ready  out  1

Behaviour:
- Read FSM states: R_IDLE, R_IFU, R_LSU. State is registered; reset forces R_IDLE.
- Registers:
  - last_grant: reset = LSU, so the IFU wins the first tie.
  - ar_done: reset = 0.
- Transitions out of R_IDLE:
  - Only ifu_ar_valid high -> R_IFU.
  - Only lsu_ar_valid high -> R_LSU.
  - Both high -> grant the master that is not last_grant.
  - Neither high -> stay in R_IDLE.
  - The granted master is recorded in last_grant on the transition.
- Latency: arbitration costs exactly one cycle. s_ar_valid is never asserted in R_IDLE.
- Address phase in R_IFU/R_LSU:
  - While ar_done=0: s_ar_* = granted master's ar_* (combinational), and the granted master's ar_ready = s_ar_ready.
  - s_ar_valid & s_ar_ready sets ar_done=1. From then on s_ar_valid=0 and the granted master's ar_ready=0.
- Data phase:
  - s_r_* are routed to the granted master; s_r_ready = granted master's r_ready.
  - The non-granted master always sees ar_ready=0 and r_valid=0. Its r_data/resp/last are don't-care and are driven 0.
- Burst end: s_r_valid & s_r_ready & s_r_last -> R_IDLE next cycle, ar_done cleared. There is no grant change mid-burst.
- A request held valid by the losing master is served next, one idle cycle after the burst ends.
- Constant fields: s_ar_prot = s_aw_prot = 3'b000; s_ar_burst = s_aw_burst = 2'b01 (INCR).
- Write pass-through:
  - s_aw_*/s_w_* = lsu_aw_*/lsu_w_*.
  - lsu_aw_ready = s_aw_ready, lsu_w_ready = s_w_ready.
  - lsu_b_valid/resp = s_b_*, s_b_ready = lsu_b_ready.
  - A write may overlap any read grant.
- While rst=1, every valid/ready output (master-side and slave-side) is forced to 0 and all data outputs read 0.
- Reset mid-burst:
  - The FSM returns to R_IDLE and ar_done clears. The slave is reset on the same rst, so no completion is owed to any master.
  - After reset release, arbitration restarts from last_grant = LSU.
- s_r_valid arriving in R_IDLE (protocol error): s_r_ready=0, and nothing is forwarded to either master.

Test Plan:
- IFU alone, ar_addr=0x8000_0000, len=0 -> s_ar_valid rises 1 cycle after ifu_ar_valid. R beat delivered to IFU only; lsu_r_valid stays 0. FSM back in R_IDLE the cycle after r_last.
- Simultaneous IFU and LSU requests after reset -> IFU granted first, LSU served second. Next simultaneous pair -> LSU first (round-robin).
- LSU read with len=1, IFU requests mid-burst -> both beats go to LSU. IFU ar_ready stays 0 until the LSU burst ends, then the IFU is granted 1 cycle later.
- LSU write addr=0x8000_0010, data=0x1122_3344_5566_7788, strb=0xFF, overlapping an IFU read -> AW/W/B pass through unchanged with b_resp=0. The IFU read completes correctly.
- rst asserted while in R_LSU after the AR handshake -> all valid/ready outputs are 0 during reset and the FSM is in R_IDLE. A new IFU request after release is granted normally.
- s_ar_ready held low for 5 cycles -> the granted master's addr is stable on s_ar_addr throughout. ifu_ar_ready mirrors s_ar_ready, and ar_done sets only on the handshake cycle.
